sample_capture: RTL

Acquisition front-end of the oscilloscope: accepts an 8-bit sample stream, detects a level/slope trigger, and writes one 256-sample record into a register buffer. The buffer is presented as an unpacked array that the display renderer reads every frame. The block is the writer side of that sample buffer. It holds a completed record stable until it is re-armed, either by a software pulse or automatically on a frame boundary.

---
 rtl/vga_pkg.sv | 17 +
 rtl/sample_capture_trigger_detect.sv | 58 +++++
 rtl/sample_capture.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the acquisition front-end and the display
// path that reads its sample buffer.
package vga_pkg;

  localparam int SAMPLE_W  = 8;
  localparam int BUF_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } capture_state_t;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_capture_trigger_detect.sv
// Level/slope trigger detector. Remembers the previous accepted sample and
// flags a crossing of trig_level by the current one. clear_i forgets the
// previous sample so a fresh arm always needs one sample to prime.
module trigger_detect
  import vga_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] trig_level_i,
  input  logic             trig_slope_i,
  output logic             hit_o
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_ok_q, prev_ok_d;

  // Next value of the remembered sample: forget on clear, load on accept.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    if (clear_i) begin
      prev_ok_d = 1'b0;
    end else if (en_i) begin
      prev_d    = cur_i;
      prev_ok_d = 1'b1;
    end
  end

  // Previous-sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its sources.
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
    end
  end

  // Crossing test against the threshold for the selected slope.
  always_comb begin
    hit_o = 1'b0;
    if (prev_ok_q) begin
      if (trig_slope_i) hit_o = (prev_q > trig_level_i) && (cur_i <= trig_level_i);
      else              hit_o = (prev_q < trig_level_i) && (cur_i >= trig_level_i);
    end
  end

endmodule

// File: rtl/sample_capture.sv
// Oscilloscope acquisition front-end: decimates the incoming sample stream,
// waits for a level/slope trigger and writes one DEPTH-sample record into a
// register buffer that the display reads directly. A finished record is held
// until re-armed by arm or, in auto mode, by frame_start.
// Optional build macro CAPTURE_TIMEOUT_EN: forces a trigger after TIMEOUT
// accepted samples in ARMED and reports it on forced.
module sample_capture
  import vga_pkg::*;
#(
  parameter int DEPTH   = BUF_DEPTH,
  parameter int WIDTH   = SAMPLE_W,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] trig_level,
  input  logic             trig_slope,
  input  logic [3:0]       decim,
  input  logic             arm,
  input  logic             auto_mode,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data [0:DEPTH-1],
  output logic             busy,
  output logic             done,
  output logic             forced
);

  localparam int PTR_W = $clog2(DEPTH);

  capture_state_t   state_q, state_d;
  logic [3:0]       dec_cnt_q, dec_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             rearm_req;
  logic             enter_armed;
  logic             hit;
  logic             timeout_hit;
  logic             trig_fire;
  logic             last_write;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;

  // Only every (decim+1)-th valid sample takes part in triggering and storage.
  assign accept      = sample_valid && (dec_cnt_q == decim);
  // arm and an auto-mode frame_start arriving together still mean one re-arm.
  assign rearm_req   = arm || (auto_mode && frame_start);
  assign enter_armed = ((state_q == IDLE) || (state_q == HOLD)) && rearm_req;
  assign trig_fire   = (state_q == ARMED) && accept && (hit || timeout_hit);
  assign last_write  = (state_q == CAPTURE) && accept && (wr_ptr_q == PTR_W'(DEPTH - 1));

  trigger_detect #(
    .WIDTH(WIDTH)
  ) u_trigger_detect (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (enter_armed),
    .en_i        ((state_q == ARMED) && accept),
    .cur_i       (sample_in),
    .trig_level_i(trig_level),
    .trig_slope_i(trig_slope),
    .hit_o       (hit)
  );

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            forced_q, forced_d;

  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign forced      = forced_q;

  // Accepted-sample count while waiting for a trigger; a forced start is
  // flagged only when the real trigger did not fire on the same sample.
  always_comb begin
    to_cnt_d = to_cnt_q;
    forced_d = forced_q;
    if (enter_armed)                           to_cnt_d = '0;
    else if ((state_q == ARMED) && accept)     to_cnt_d = to_cnt_q + TO_W'(1);
    if (trig_fire)                             forced_d = !hit;
  end

  // Timeout counter and forced flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      forced_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      forced_q <= forced_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign forced      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; re-arm requests are ignored while ARMED or capturing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rearm_req)  state_d = ARMED;
      ARMED:   if (trig_fire)  state_d = CAPTURE;
      CAPTURE: if (last_write) state_d = HOLD;
      HOLD:    if (rearm_req)  state_d = ARMED;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath and output decode: decimation counter, write pointer, buffer
  // write strobe and the registered status flags.
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    wr_en     = 1'b0;
    wr_addr   = wr_ptr_q;
    if (enter_armed)       dec_cnt_d = '0;
    else if (sample_valid) dec_cnt_d = accept ? 4'd0 : dec_cnt_q + 4'd1;

    if (trig_fire) begin
      wr_en    = 1'b1;
      wr_addr  = '0;
      wr_ptr_d = PTR_W'(1);
    end else if ((state_q == CAPTURE) && accept) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    busy_d = (state_d == ARMED) || (state_d == CAPTURE);
    done_d = last_write;
  end

  // Counter, pointer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q <= '0;
      wr_ptr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Sample buffer; the display reads it directly, so it is cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this buffer is reset because the display must show zeros after
      // an aborted capture; that rules out a RAM macro and is intentional.
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
    end else if (wr_en) begin
      data[wr_addr] <= sample_in;
    end
  end

endmodule
